// File: rtl/buf_arb_pkg.sv
// Shared types and constants for the buffer port arbiter: access-mode encodings,
// the read-return pipeline entry and the default buffer read latency.
package buf_arb_pkg;

  localparam int MAX_REQ            = 8;
  localparam int RD_ID_W            = $clog2(MAX_REQ);
  localparam int DEFAULT_RD_LATENCY = 1;

  localparam logic MODE_BYTE = 1'b0;
  localparam logic MODE_WORD = 1'b1;

  // One slot of the in-flight read tracker; id is wide enough for any legal NumReq.
  typedef struct packed {
    logic               valid;
    logic [RD_ID_W-1:0] id;
  } rd_entry_t;

endpackage

// File: rtl/rr_grant.sv
// Round-robin grant: a last-grant pointer plus a masked priority search starting at pointer+1.
// An optional override index takes priority over the rotation (used for grant locking).
module rr_grant #(
  parameter int N    = 3,
  parameter int IdxW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            force_valid,
  input  logic [IdxW-1:0] force_idx,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] grant_idx,
  output logic            grant_any,
  output logic [IdxW-1:0] last_idx
);

  logic [IdxW-1:0] ptr_reg;
  logic            found;
  logic [IdxW-1:0] sel_idx;
  logic [IdxW-1:0] cand_idx;
  int              cand;

  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N; k++) begin
      cand     = (int'(ptr_reg) + k) % N;
      cand_idx = IdxW'(cand);
      if (!found && req[cand_idx]) begin
        found   = 1'b1;
        sel_idx = cand_idx;
      end
    end
    if (force_valid) begin
      found   = 1'b1;
      sel_idx = force_idx;
    end
  end

  assign grant_any = found;
  assign grant_idx = sel_idx;
  assign grant     = found ? ({{(N-1){1'b0}}, 1'b1} << sel_idx) : '0;
  assign last_idx  = ptr_reg;

  // Pointer starts at the last index so that requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= IdxW'(N - 1);
    end else if (found) begin
      ptr_reg <= sel_idx;
    end
  end

endmodule

// File: rtl/buf_port_arbiter.sv
// Shares one byte/word buffer between NumReq requesters: round-robin grant, registered
// buffer command, and in-order read return routed by id. Optional grant lock: BUF_ARB_LOCK_EN.
module buf_port_arbiter
  import buf_arb_pkg::*;
#(
  parameter int NumReq    = 3,
  parameter int BuffDepth = 256,
  parameter int ByteAddrW = $clog2(BuffDepth),
  parameter int WordAddrW = $clog2(BuffDepth / 8),
  parameter int RdLatency = DEFAULT_RD_LATENCY,
  parameter int MaxLock   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NumReq-1:0]             req_valid,
  output logic [NumReq-1:0]             req_ready,
  input  logic [NumReq-1:0]             req_write,
  input  logic [NumReq-1:0]             req_mode,
  input  logic [NumReq-1:0]             req_lock,
  input  logic [NumReq*ByteAddrW-1:0]   req_byte_addr,
  input  logic [NumReq*WordAddrW-1:0]   req_word_addr,
  input  logic [NumReq*8-1:0]           req_byte_in,
  input  logic [NumReq*64-1:0]          req_word_in,
  output logic [NumReq-1:0]             rsp_valid,
  output logic [7:0]                    rsp_byte_out,
  output logic [63:0]                   rsp_word_out,
  output logic                          buf_write_en,
  output logic                          buf_read_en,
  output logic                          buf_addr_mode,
  output logic [ByteAddrW-1:0]          buf_byte_addr,
  output logic [WordAddrW-1:0]          buf_word_addr,
  output logic [7:0]                    buf_byte_in,
  output logic [63:0]                   buf_word_in,
  input  logic [7:0]                    buf_byte_out,
  input  logic [63:0]                   buf_word_out
);

  localparam int IdxW = $clog2(NumReq);

  logic [IdxW-1:0]      grant_idx;
  logic                 grant_any;
  logic [IdxW-1:0]      last_idx;
  logic                 force_vld;
  logic [IdxW-1:0]      force_idx;
  logic [RD_ID_W-1:0]   cmd_id_reg;
  rd_entry_t            rd_pipe_reg [RdLatency];

  logic [ByteAddrW-1:0] byte_addr_arr [NumReq];
  logic [WordAddrW-1:0] word_addr_arr [NumReq];
  logic [7:0]           byte_in_arr   [NumReq];
  logic [63:0]          word_in_arr   [NumReq];

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
    assign byte_addr_arr[gi] = req_byte_addr[gi*ByteAddrW +: ByteAddrW];
    assign word_addr_arr[gi] = req_word_addr[gi*WordAddrW +: WordAddrW];
    assign byte_in_arr[gi]   = req_byte_in[gi*8 +: 8];
    assign word_in_arr[gi]   = req_word_in[gi*64 +: 64];
  end

  rr_grant #(
    .N    (NumReq),
    .IdxW (IdxW)
  ) u_rr_grant (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req_valid),
    .force_valid (force_vld),
    .force_idx   (force_idx),
    .grant       (req_ready),
    .grant_idx   (grant_idx),
    .grant_any   (grant_any),
    .last_idx    (last_idx)
  );

`ifdef BUF_ARB_LOCK_EN
  localparam int LockCntW = $clog2(MaxLock + 1);

  logic [LockCntW-1:0] lock_cnt_reg;
  logic                last_vld_reg;

  // lock_cnt_reg counts re-grants beyond the first, so MaxLock-1 re-grants cap the run at MaxLock.
  assign force_vld = last_vld_reg && req_valid[last_idx] && req_lock[last_idx] &&
                     (lock_cnt_reg < LockCntW'(MaxLock - 1));
  assign force_idx = last_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_reg <= '0;
      last_vld_reg <= 1'b0;
    end else if (grant_any) begin
      last_vld_reg <= 1'b1;
      if (last_vld_reg && (grant_idx == last_idx)) begin
        if (lock_cnt_reg != LockCntW'(MaxLock))
          lock_cnt_reg <= lock_cnt_reg + 1'b1;
      end else begin
        lock_cnt_reg <= '0;
      end
    end
  end
`else
  logic unused_lock;

  assign force_vld   = 1'b0;
  assign force_idx   = '0;
  assign unused_lock = (^req_lock) ^ (MaxLock > 0) ^ (^last_idx);
`endif

  // Enables drop to zero on idle cycles; address and data registers keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_write_en  <= 1'b0;
      buf_read_en   <= 1'b0;
      buf_addr_mode <= MODE_BYTE;
      buf_byte_addr <= '0;
      buf_word_addr <= '0;
      buf_byte_in   <= '0;
      buf_word_in   <= '0;
      cmd_id_reg    <= '0;
    end else begin
      buf_write_en <= grant_any &  req_write[grant_idx];
      buf_read_en  <= grant_any & ~req_write[grant_idx];
      if (grant_any) begin
        buf_addr_mode <= (req_mode[grant_idx] == MODE_WORD);
        buf_byte_addr <= byte_addr_arr[grant_idx];
        buf_word_addr <= word_addr_arr[grant_idx];
        buf_byte_in   <= byte_in_arr[grant_idx];
        buf_word_in   <= word_in_arr[grant_idx];
        cmd_id_reg    <= RD_ID_W'(grant_idx);
      end
    end
  end

  // Stage 0 captures the command as the buffer samples it; the last stage lines up with read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RdLatency; k++)
        rd_pipe_reg[k] <= '0;
    end else begin
      rd_pipe_reg[0] <= '{valid: buf_read_en, id: cmd_id_reg};
      for (int k = 1; k < RdLatency; k++)
        rd_pipe_reg[k] <= rd_pipe_reg[k-1];
    end
  end

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_rsp
    assign rsp_valid[gi] = rd_pipe_reg[RdLatency-1].valid &&
                           (rd_pipe_reg[RdLatency-1].id == RD_ID_W'(gi));
  end

  assign rsp_byte_out = buf_byte_out;
  assign rsp_word_out = buf_word_out;

endmodule

// File: tb/tb_buf_port_arbiter.sv
// Directed bench for buf_port_arbiter with a behavioural byte/word buffer of matching read latency.
// Lock-specific expectations follow BUF_ARB_LOCK_EN.
module tb_buf_port_arbiter;

  localparam int NR  = 3;
  localparam int BAW = 8;
  localparam int WAW = 5;
  localparam int RDL = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_ready, req_write, req_mode, req_lock, rsp_valid;
  logic [NR*BAW-1:0] req_byte_addr;
  logic [NR*WAW-1:0] req_word_addr;
  logic [NR*8-1:0]   req_byte_in;
  logic [NR*64-1:0]  req_word_in;
  logic [7:0]        rsp_byte_out, buf_byte_in, buf_byte_out;
  logic [63:0]       rsp_word_out, buf_word_in, buf_word_out;
  logic              buf_write_en, buf_read_en, buf_addr_mode;
  logic [BAW-1:0]    buf_byte_addr;
  logic [WAW-1:0]    buf_word_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  buf_port_arbiter #(
    .NumReq(NR), .BuffDepth(256), .RdLatency(RDL), .MaxLock(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_mode(req_mode), .req_lock(req_lock),
    .req_byte_addr(req_byte_addr), .req_word_addr(req_word_addr),
    .req_byte_in(req_byte_in), .req_word_in(req_word_in),
    .rsp_valid(rsp_valid), .rsp_byte_out(rsp_byte_out), .rsp_word_out(rsp_word_out),
    .buf_write_en(buf_write_en), .buf_read_en(buf_read_en), .buf_addr_mode(buf_addr_mode),
    .buf_byte_addr(buf_byte_addr), .buf_word_addr(buf_word_addr),
    .buf_byte_in(buf_byte_in), .buf_word_in(buf_word_in),
    .buf_byte_out(buf_byte_out), .buf_word_out(buf_word_out)
  );

  // Behavioural buffer: samples the command on the edge, read data emerges RDL edges later.
  logic [7:0]  mem [256];
  logic [7:0]  rb_pipe [RDL];
  logic [63:0] rw_pipe [RDL];

  function automatic logic [63:0] word_at(input logic [WAW-1:0] wa);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[b*8 +: 8] = mem[{wa, 3'(b)}];
    return w;
  endfunction

  always @(posedge clk) begin
    if (buf_write_en) begin
      if (buf_addr_mode) begin
        for (int b = 0; b < 8; b++) mem[{buf_word_addr, 3'(b)}] <= buf_word_in[b*8 +: 8];
      end else begin
        mem[buf_byte_addr] <= buf_byte_in;
      end
    end
    if (buf_read_en) begin
      rb_pipe[0] <= mem[buf_byte_addr];
      rw_pipe[0] <= word_at(buf_word_addr);
    end
    for (int k = 1; k < RDL; k++) begin
      rb_pipe[k] <= rb_pipe[k-1];
      rw_pipe[k] <= rw_pipe[k-1];
    end
  end

  assign buf_byte_out = rb_pipe[RDL-1];
  assign buf_word_out = rw_pipe[RDL-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [NR-1:0] g;
    g = req_ready;
    @(posedge clk);
    #1;
    if (g != '0)
      $display("txn t=%0t grant=%b wr=%b rd=%b mode=%b baddr=%0d waddr=%0d",
               $time, g, buf_write_en, buf_read_en, buf_addr_mode, buf_byte_addr, buf_word_addr);
  endtask

  task automatic drive(input int i, input logic v, input logic w, input logic m, input logic lk,
                       input logic [7:0] ba, input logic [4:0] wa,
                       input logic [7:0] bd, input logic [63:0] wd);
    req_valid[i]               = v;
    req_write[i]               = w;
    req_mode[i]                = m;
    req_lock[i]                = lk;
    req_byte_addr[i*BAW +: BAW] = ba;
    req_word_addr[i*WAW +: WAW] = wa;
    req_byte_in[i*8 +: 8]      = bd;
    req_word_in[i*64 +: 64]    = wd;
  endtask

  task automatic clear_all();
    req_valid = '0; req_write = '0; req_mode = '0; req_lock = '0;
  endtask

  // Counts edges (after the current one) until a response appears, bounded.
  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid == '0 && n < 10) begin
      tick();
      n++;
    end
  endtask

  int          n;
  logic [NR-1:0] seen;
  int          exp_seq [5];

  initial begin
    rst_n = 1'b0;
    clear_all();
    req_byte_addr = '0; req_word_addr = '0; req_byte_in = '0; req_word_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_write_en", 64'(buf_write_en), 64'd0);
    chk("rst_read_en", 64'(buf_read_en), 64'd0);
    chk("rst_byte_addr", 64'(buf_byte_addr), 64'd0);
    chk("rst_word_in", buf_word_in, 64'd0);
    chk("rst_addr_mode", 64'(buf_addr_mode), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_ready", 64'(req_ready), 64'd0);
    tick();

    // All three valid: strict rotation starting at requester 0.
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < NR; i++) drive(i, 1, 1, 0, 0, 8'(100 + i), 5'd0, 8'(i), 64'd0);
      #1;
      chk($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(3'b001 << (k % 3)));
      tick();
      chk($sformatf("rr_addr_%0d", k), 64'(buf_byte_addr), 64'(100 + (k % 3)));
    end
    clear_all();
    tick();
    chk("idle_no_cmd", 64'({buf_write_en, buf_read_en}), 64'd0);

    // Byte write then read-back from requester 0.
    drive(0, 1, 1, 0, 0, 8'd23, 5'd0, 8'hFF, 64'd0);
    #1;
    chk("t1_ready_wr", 64'(req_ready), 64'b001);
    tick();
    chk("t1_write_en", 64'({buf_write_en, buf_read_en}), 64'b10);
    chk("t1_byte_addr", 64'(buf_byte_addr), 64'd23);
    chk("t1_byte_in", 64'(buf_byte_in), 64'hFF);
    chk("t1_mode", 64'(buf_addr_mode), 64'd0);
    drive(0, 1, 0, 0, 0, 8'd23, 5'd0, 8'h00, 64'd0);
    #1;
    chk("t1_ready_rd", 64'(req_ready), 64'b001);
    tick();
    chk("t1_read_en", 64'({buf_write_en, buf_read_en}), 64'b01);
    clear_all();
    wait_rsp(n);
    chk("t1_latency", 64'(n), 64'(RDL));
    chk("t1_rsp_valid", 64'(rsp_valid), 64'b001);
    chk("t1_rsp_byte", 64'(rsp_byte_out), 64'hFF);
    tick();
    chk("t1_rsp_single", 64'(rsp_valid), 64'd0);

    // Word write then read-back from requester 1.
    drive(1, 1, 1, 1, 0, 8'd0, 5'd7, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    chk("t2_ready_wr", 64'(req_ready), 64'b010);
    tick();
    chk("t2_wr_mode", 64'({buf_write_en, buf_addr_mode}), 64'b11);
    chk("t2_word_addr", 64'(buf_word_addr), 64'd7);
    chk("t2_word_in", buf_word_in, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1, 1, 0, 1, 0, 8'd0, 5'd7, 8'd0, 64'd0);
    #1;
    chk("t2_ready_rd", 64'(req_ready), 64'b010);
    tick();
    chk("t2_rd_mode", 64'({buf_read_en, buf_addr_mode}), 64'b11);
    clear_all();
    wait_rsp(n);
    chk("t2_latency", 64'(n), 64'(RDL));
    chk("t2_rsp_valid", 64'(rsp_valid), 64'b010);
    chk("t2_rsp_word", rsp_word_out, 64'hFFFF_FFFF_FFFF_FFFF);

    // Back-to-back reads from requester 2 then requester 0 return in order.
    drive(2, 1, 0, 0, 0, 8'd23, 5'd0, 8'd0, 64'd0);
    #1;
    chk("t4_ready_a", 64'(req_ready), 64'b100);
    tick();
    clear_all();
    drive(0, 1, 0, 1, 0, 8'd0, 5'd7, 8'd0, 64'd0);
    #1;
    chk("t4_ready_b", 64'(req_ready), 64'b001);
    tick();
    clear_all();
    wait_rsp(n);
    chk("t4_latency", 64'(n), 64'(RDL - 1));
    chk("t4_rsp_a", 64'(rsp_valid), 64'b100);
    chk("t4_byte_a", 64'(rsp_byte_out), 64'hFF);
    tick();
    chk("t4_rsp_b", 64'(rsp_valid), 64'b001);
    chk("t4_word_b", rsp_word_out, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("t4_rsp_end", 64'(rsp_valid), 64'd0);

    // Asynchronous reset with two reads in flight.
    drive(1, 1, 0, 0, 0, 8'd23, 5'd0, 8'd0, 64'd0);
    #1;
    chk("t5_ready_a", 64'(req_ready), 64'b010);
    tick();
    clear_all();
    drive(2, 1, 0, 0, 0, 8'd23, 5'd0, 8'd0, 64'd0);
    #1;
    chk("t5_ready_b", 64'(req_ready), 64'b100);
    tick();
    clear_all();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_read_en", 64'(buf_read_en), 64'd0);
    chk("t5_async_addr", 64'(buf_byte_addr), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = '0;
    for (int k = 0; k < 6; k++) begin
      seen |= rsp_valid;
      tick();
    end
    chk("t5_no_rsp", 64'(seen), 64'd0);
    for (int i = 0; i < NR; i++) drive(i, 1, 1, 0, 0, 8'(200 + i), 5'd0, 8'd0, 64'd0);
    #1;
    chk("t5_first_grant", 64'(req_ready), 64'b001);
    tick();
    clear_all();

    // Requester 1 asserts lock while 0 and 2 stay valid.
`ifdef BUF_ARB_LOCK_EN
    exp_seq = '{1, 1, 1, 1, 2};
`else
    exp_seq = '{1, 2, 0, 1, 2};
`endif
    drive(0, 1, 1, 0, 0, 8'd40, 5'd0, 8'd0, 64'd0);
    drive(1, 1, 1, 0, 1, 8'd41, 5'd0, 8'd0, 64'd0);
    drive(2, 1, 1, 0, 0, 8'd42, 5'd0, 8'd0, 64'd0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("lock_grant_%0d", k), 64'(req_ready), 64'(3'b001 << exp_seq[k]));
      tick();
    end
    clear_all();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/buf_port_arbiter.md
Name: buf_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one buffer_64bit instance (byte/word addressed, 64-bit words) between NumReq requesters, e.g. DMA fill, PE operand fetch and result writeback.
- Accepts one request per cycle via valid/ready and drives the buffer command from registers.
- Tracks in-flight reads through a latency pipeline and routes read data back to the issuing requester.

Parameters:
- NumReq, 3, number of requesters (2..8).
- BuffDepth, 256, buffer depth in bytes.
- ByteAddrW, $clog2(BuffDepth), byte address width.
- WordAddrW, $clog2(BuffDepth/8), word address width.
- RdLatency, 1, edges from buffer sampling read_en to valid read data (1..4).
- MaxLock, 4, maximum consecutive grants under lock (feature only).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NumReq  request pending, one bit per requester.
- req_ready  out  NumReq  grant this cycle (combinational, one-hot or zero).
- req_write  in  NumReq  1=write, 0=read.
- req_mode  in  NumReq  0=byte, 1=word.
- req_lock  in  NumReq  hold grant (ignored without feature).
- req_byte_addr  in  NumReq*ByteAddrW  packed per requester.
- req_word_addr  in  NumReq*WordAddrW  packed per requester.
- req_byte_in  in  NumReq*8  byte write data.
- req_word_in  in  NumReq*64  word write data.
- rsp_valid  out  NumReq  one-hot read-data strobe.
- rsp_byte_out  out  8  shared read byte.
- rsp_word_out  out  64  shared read word.
- buf_write_en, buf_read_en, buf_addr_mode  out  1  buffer command.
- buf_byte_addr  out  ByteAddrW;  buf_word_addr  out  WordAddrW.
- buf_byte_in  out  8;  buf_word_in  out  64.
- buf_byte_out  in  8;  buf_word_out  in  64  buffer read data.

Behaviour:
- Reset: all buf_* outputs 0, rsp_valid 0, read pipeline cleared, rr pointer = NumReq-1 so requester 0 wins first. Reset mid-operation drops in-flight reads; no rsp_valid is produced for them.
- Arbitration:
  - Search starts at pointer+1 and wraps modulo NumReq; the first asserted req_valid gets req_ready.
  - Pointer updates to the granted index only on a grant. No valid gives no grant and the pointer holds.
  - Transfer occurs when req_valid && req_ready at edge E. Requesters must hold their fields stable while valid.
- Command:
  - At E, buf_* registers load the granted requester's fields, with write_en=req_write and read_en=~req_write. The buffer samples the command at E+1.
  - With no transfer at E, buf_write_en and buf_read_en are 0 for the next cycle. Address and data registers hold their values.
  - buf_write_en and buf_read_en are never both 1.
- Read return:
  - A pipeline of depth RdLatency carries {valid, id}.
  - rsp_valid[id] is high for exactly one cycle after edge E+RdLatency. rsp_byte_out/rsp_word_out pass buf_*_out during that cycle.
  - Writes produce no response.
  - Back-to-back reads give one response per cycle, returned in order.
- Throughput: one access per cycle sustained. A requester holding valid waits at most NumReq-1 grants.
- Read-after-write to the same address in consecutive grants returns the new data (buffer ordering preserved, no reordering).

Optional Feature:
- BUF_ARB_LOCK_EN defined:
  - If the last-granted requester holds req_valid && req_lock, it is re-granted ahead of round-robin, up to MaxLock consecutive grants.
  - After MaxLock consecutive grants, or when lock drops, rotation resumes from that requester+1.
  - The lock counter resets to 0 on rst_n and on any change of grantee.
- Undefined: req_lock is ignored and arbitration is pure round-robin. The port stays present.

Decomposition:
- Package buf_arb_pkg holds the mode encodings (MODE_BYTE=0, MODE_WORD=1), the rd-pipeline entry typedef {valid, id[$clog2(NumReq)-1:0]}, and a default-latency constant.
- One sub-module, rr_grant: pointer plus masked priority search, producing the one-hot grant and index. Reusable for other shared resources.

Test Plan:
- Single requester: req0 writes byte 0xFF at addr 23, then reads addr 23 -> buf_write_en one cycle, later rsp_valid[0] with rsp_byte_out=0xFF after RdLatency+1 edges.
- Word path: req1 writes 64'hFFFF_FFFF_FFFF_FFFF at word 7, then reads it -> rsp_valid[1] with rsp_word_out all ones. buf_addr_mode=1 on both commands.
- All three requesters hold valid for 9 cycles -> grant order 0,1,2,0,1,2,0,1,2. No requester is granted twice in a row.
- Interleaved reads from req2 then req0, with RdLatency=3 -> responses in order, rsp_valid one-hot, ids 2 then 0, one per cycle.
- rst_n pulsed low with two reads in flight -> no rsp_valid afterwards. All outputs 0 asynchronously. Next grant goes to req0.
- With BUF_ARB_LOCK_EN, MaxLock=4: req1 locks while req0 and req2 are valid -> req1 granted 4 consecutive cycles, then req2.
